// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Registered PC with branch/jump select, stall, single-level trap
//            and return, and sticky halt. Optional misaligned-target trap is
//            built when PC_MISALIGN_TRAP_EN is defined.
// Revision : 1.0
// ============================================================================
module pc_sequencer #(
    parameter int unsigned PC_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned TRAP_VECTOR  = 'h40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic [3:0]            s_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic                  trap_req_i,
    input  logic                  mret_i,
    input  logic                  halt_i,
    output logic [PC_WIDTH-1:0]   pc_o,
    output logic [PC_WIDTH-1:0]   pc_plus4_o,
    output logic [PC_WIDTH-1:0]   epc_o,
    output logic                  in_trap_o,
    output logic                  trap_cause_o,
    output logic                  halted_o
);

    localparam logic [PC_WIDTH-1:0] C_RESET_PC = RESET_VECTOR[PC_WIDTH-1:0];
    localparam logic [PC_WIDTH-1:0] C_TRAP_PC  = TRAP_VECTOR[PC_WIDTH-1:0];

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_TRAP = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                state_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   epc_q;
    logic                  in_trap_q;
    logic                  trap_cause_q;
    logic                  halted_q;

    logic [DATA_WIDTH-1:0] imm_shl;
    logic [PC_WIDTH-1:0]   pc_plus4;
    logic [PC_WIDTH-1:0]   branch_target;
    logic [PC_WIDTH-1:0]   target_d;
    logic                  is_jump;
    logic                  misalign_trap;

    // The immediate is scaled at full data width before truncation to the PC.
    assign imm_shl       = imm_i << 1;
    assign pc_plus4      = pc_q + PC_WIDTH'(4);
    assign branch_target = pc_q + imm_shl[PC_WIDTH-1:0];

    always_comb begin
        target_d = pc_plus4;
        is_jump  = 1'b0;
        casez (s_i)
            4'b111?: begin
                target_d = branch_target;
                is_jump  = 1'b1;
            end
            4'b101?: begin
                target_d = {alu_result_i[PC_WIDTH-1:1], 1'b0};
                is_jump  = 1'b1;
            end
            4'b1001: begin
                target_d = branch_target;
                is_jump  = 1'b1;
            end
            default: begin
                target_d = pc_plus4;
                is_jump  = 1'b0;
            end
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_trap = (state_q == ST_RUN) && is_jump && (target_d[1:0] != 2'b00);
`else
    logic unused_is_jump;
    assign unused_is_jump = is_jump;
    assign misalign_trap  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            pc_q         <= C_RESET_PC;
            epc_q        <= '0;
            in_trap_q    <= 1'b0;
            trap_cause_q <= 1'b0;
            halted_q     <= 1'b0;
        end else if (state_q != ST_HALT) begin
            if (halt_i) begin
                state_q  <= ST_HALT;
                halted_q <= 1'b1;
            end else if (trap_req_i && (state_q == ST_RUN)) begin
                state_q      <= ST_TRAP;
                epc_q        <= pc_q;
                pc_q         <= C_TRAP_PC;
                in_trap_q    <= 1'b1;
                trap_cause_q <= 1'b0;
            end else if (misalign_trap) begin
                state_q      <= ST_TRAP;
                epc_q        <= pc_q;
                pc_q         <= C_TRAP_PC;
                in_trap_q    <= 1'b1;
                trap_cause_q <= 1'b1;
            end else if (mret_i && (state_q == ST_TRAP)) begin
                state_q   <= ST_RUN;
                pc_q      <= epc_q;
                in_trap_q <= 1'b0;
            end else if (!stall_i) begin
                pc_q <= target_d;
            end
        end
    end

    assign pc_o         = pc_q;
    assign pc_plus4_o   = pc_plus4;
    assign epc_o        = epc_q;
    assign in_trap_o    = in_trap_q;
    assign trap_cause_o = trap_cause_q;
    assign halted_o     = halted_q;

    // Bits of the wide inputs that never reach the PC.
    logic unused_bits;
    assign unused_bits = ^{imm_shl[DATA_WIDTH-1:PC_WIDTH],
                           alu_result_i[DATA_WIDTH-1:PC_WIDTH],
                           alu_result_i[0]};

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer.
// Revision : 1.0
// ============================================================================
module tb_pc_sequencer;

    localparam int unsigned PC_WIDTH   = 8;
    localparam int unsigned DATA_WIDTH = 32;

    logic                  clk;
    logic                  rst_n;
    logic                  stall_i;
    logic [3:0]            s_i;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] alu_result_i;
    logic                  trap_req_i;
    logic                  mret_i;
    logic                  halt_i;
    logic [PC_WIDTH-1:0]   pc_o;
    logic [PC_WIDTH-1:0]   pc_plus4_o;
    logic [PC_WIDTH-1:0]   epc_o;
    logic                  in_trap_o;
    logic                  trap_cause_o;
    logic                  halted_o;

    int n_checks;
    int n_passed;

    pc_sequencer #(
        .PC_WIDTH    (PC_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VECTOR(0),
        .TRAP_VECTOR ('h40)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_i     (stall_i),
        .s_i         (s_i),
        .imm_i       (imm_i),
        .alu_result_i(alu_result_i),
        .trap_req_i  (trap_req_i),
        .mret_i      (mret_i),
        .halt_i      (halt_i),
        .pc_o        (pc_o),
        .pc_plus4_o  (pc_plus4_o),
        .epc_o       (epc_o),
        .in_trap_o   (in_trap_o),
        .trap_cause_o(trap_cause_o),
        .halted_o    (halted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_i      = 1'b0;
        s_i          = 4'b0000;
        imm_i        = '0;
        alu_result_i = '0;
        trap_req_i   = 1'b0;
        mret_i       = 1'b0;
        halt_i       = 1'b0;
    endtask

    task automatic set_pc(input logic [7:0] v);
        idle_inputs();
        s_i          = 4'b1010;
        alu_result_i = {24'h0, v};
        step();
        check("set_pc", {24'h0, pc_o}, {24'h0, v});
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_passed = 0;
        idle_inputs();
        rst_n = 1'b0;
        #23;
        check("rst_pc",      {24'h0, pc_o},       32'h00);
        check("rst_epc",     {24'h0, epc_o},      32'h00);
        check("rst_pc4",     {24'h0, pc_plus4_o}, 32'h04);
        check("rst_in_trap", {31'h0, in_trap_o},  32'h0);
        check("rst_cause",   {31'h0, trap_cause_o}, 32'h0);
        check("rst_halted",  {31'h0, halted_o},   32'h0);
        rst_n = 1'b1;

        // Sequential fetch
        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq_pc",  {24'h0, pc_o},       32'(i * 4));
            check("seq_pc4", {24'h0, pc_plus4_o}, 32'(i * 4 + 4));
        end

        // Wrap at top of address space
        set_pc(8'hFC);
        check("wrap_pc4", {24'h0, pc_plus4_o}, 32'h00);
        step();
        check("wrap_pc", {24'h0, pc_o}, 32'h00);

        // Relative branch backwards, then indirect jump with bit 0 cleared
        set_pc(8'h10);
        s_i   = 4'b1110;
        imm_i = 32'hFFFF_FFFC;
        step();
        check("br_neg", {24'h0, pc_o}, 32'h08);
        s_i          = 4'b1010;
        alu_result_i = 32'h35;
        step();
        check("jalr", {24'h0, pc_o}, 32'h34);

        // Stall holds, release takes the branch
        set_pc(8'h20);
        stall_i = 1'b1;
        s_i     = 4'b1001;
        imm_i   = 32'd2;
        step();
        check("stall_hold", {24'h0, pc_o}, 32'h20);
        stall_i = 1'b0;
        step();
        check("stall_rel", {24'h0, pc_o}, 32'h24);

        // External trap overrides stall
        set_pc(8'h18);
        trap_req_i = 1'b1;
        stall_i    = 1'b1;
        step();
        check("trap_pc",    {24'h0, pc_o},        32'h40);
        check("trap_epc",   {24'h0, epc_o},       32'h18);
        check("trap_in",    {31'h0, in_trap_o},   32'h1);
        check("trap_cause", {31'h0, trap_cause_o}, 32'h0);
        stall_i = 1'b0;
        step();
        check("nest_epc", {24'h0, epc_o}, 32'h18);
        check("nest_pc",  {24'h0, pc_o},  32'h44);
        trap_req_i = 1'b0;
        mret_i     = 1'b1;
        step();
        check("mret_pc", {24'h0, pc_o},      32'h18);
        check("mret_in", {31'h0, in_trap_o}, 32'h0);
        step();
        check("mret_run_ign", {24'h0, pc_o}, 32'h1C);
        mret_i = 1'b0;

        // Misaligned branch target
        set_pc(8'h08);
        s_i   = 4'b1001;
        imm_i = 32'd1;
        step();
`ifdef PC_MISALIGN_TRAP_EN
        check("mis_pc",    {24'h0, pc_o},         32'h40);
        check("mis_cause", {31'h0, trap_cause_o}, 32'h1);
        check("mis_epc",   {24'h0, epc_o},        32'h08);
        step();
        check("mis_in_trap_load", {24'h0, pc_o}, 32'h42);
        s_i    = 4'b0000;
        mret_i = 1'b1;
        step();
        check("mis_mret", {24'h0, pc_o}, 32'h08);
        mret_i = 1'b0;
`else
        check("mis_pc",    {24'h0, pc_o},         32'h0A);
        check("mis_cause", {31'h0, trap_cause_o}, 32'h0);
        check("mis_in",    {31'h0, in_trap_o},    32'h0);
`endif

        // Halt is sticky and ignores trap requests
        set_pc(8'h30);
        halt_i     = 1'b1;
        trap_req_i = 1'b1;
        step();
        check("halt_flag", {31'h0, halted_o}, 32'h1);
        check("halt_pc",   {24'h0, pc_o},     32'h30);
        halt_i = 1'b0;
        step();
        check("halt_hold",  {24'h0, pc_o},      32'h30);
        check("halt_notrap", {31'h0, in_trap_o}, 32'h0);
        check("halt_sticky", {31'h0, halted_o},  32'h1);
        trap_req_i = 1'b0;

        // Asynchronous reset mid-halt, checked before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pc",     {24'h0, pc_o},     32'h00);
        check("arst_halted", {31'h0, halted_o}, 32'h0);
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_pc", {24'h0, pc_o}, 32'h04);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter unit, parametrised successor to the combinational next-PC selector. It holds the architectural PC, computes the next PC from the 4-bit branch/jump select code, and adds stall, a single-level trap/return mechanism with a saved exception PC, and a sticky halt. It sits at the front of the datapath: `pc` drives instruction memory, and the decode/ALU stage returns `s`, `imm` and `alu_result` in the same cycle.

## Interface
- `PC_WIDTH`, 8: width of PC, EPC and all PC arithmetic.
- `DATA_WIDTH`, 32: width of `imm` and `alu_result`.
- `RESET_VECTOR`, 0: PC value loaded on reset.
- `TRAP_VECTOR`, 8'h40: PC value loaded on trap entry. Truncated to `PC_WIDTH`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold PC this cycle.
- `s`  in  4  next-PC select code.
- `imm`  in  DATA_WIDTH  signed immediate, in half-word units.
- `alu_result`  in  DATA_WIDTH  indirect-jump target.
- `trap_req`  in  1  external trap request, level-sampled.
- `mret`  in  1  return from trap.
- `halt`  in  1  enter halted state.
- `pc`  out  PC_WIDTH  current PC, registered.
- `pc_plus4`  out  PC_WIDTH  `pc + 4`, combinational.
- `epc`  out  PC_WIDTH  saved exception PC, registered.
- `in_trap`  out  1  high while the trap handler runs.
- `trap_cause`  out  1  0 = external, 1 = misaligned target. Valid while `in_trap`.
- `halted`  out  1  sticky halt indicator.

## Operation
- States:
  - RUN: normal execution.
  - TRAP: handler running, `in_trap` = 1.
  - HALT: terminal until reset.
- Candidate target from `s` (casez). All arithmetic is modulo 2^PC_WIDTH.
  - 111?: `pc + (imm<<1)`. The shift is done at DATA_WIDTH, then truncated.
  - 101?: `alu_result[PC_WIDTH-1:0]` with bit 0 forced to 0.
  - 1001: `pc + (imm<<1)`.
  - Otherwise: `pc + 4`.
- Per-cycle priority, highest first:
  1. `halt`: enter HALT; PC holds.
  2. `trap_req` in RUN: `epc <= pc`, `pc <= TRAP_VECTOR`, `trap_cause <= 0`, go to TRAP.
  3. Misaligned trap, RUN only (see Configuration).
  4. `mret` in TRAP: `pc <= epc`, go to RUN.
  5. `stall`: PC holds.
  6. Otherwise `pc <= target`.
- In TRAP:
  - `trap_req` is ignored (no nesting).
  - `epc` is frozen.
  - Branches and jumps work normally.
- In RUN, `mret` is ignored and treated as a normal cycle.
- In HALT, every input except `rst_n` is ignored.
- `trap_req` and `mret` both override `stall`.
- `pc + 4` at 2^PC_WIDTH − 4 wraps to 0; no flag is raised.

## Timing
- `rst_n` low, asynchronously:
  - `pc = RESET_VECTOR`, `epc = 0`.
  - `in_trap = 0`, `trap_cause = 0`, `halted = 0`, state RUN.
- Reset mid-trap or mid-halt aborts immediately to the reset values.
- The first rising edge after `rst_n` deasserts performs a normal update.
- All state updates occur on the rising `clk` edge.
- `pc_plus4` is combinational from `pc`.
- Latency:
  - Inputs sampled at edge N take effect on `pc` in the cycle following edge N.
  - `in_trap` and `halted` change at the same edge as `pc`.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined:
  - Applies in RUN, to the branch/jump cases only (not `pc + 4`).
  - If the selected target has `target[1:0] != 0` and no higher-priority event is present, trap instead of jumping.
  - `epc <= pc`, `trap_cause <= 1`, `pc <= TRAP_VECTOR`, go to TRAP.
  - In TRAP, a misaligned target is loaded unchanged.
- Not defined:
  - The misaligned-trap check is not built; misaligned targets load unchanged.
  - `trap_cause` is only ever 0.

## Test plan
- Reset, then `s=0000`, 4 cycles, no stall: `pc` = 0, 4, 8, 12, 16; `pc_plus4` tracks; with `pc=8'hFC`, the next `pc` is 0.
- `pc=8'h10`, `s=1110`, `imm=-4`: next `pc=8'h08`. Then `s=1010`, `alu_result=32'h35`: next `pc=8'h34`.
- `pc=8'h20`, `stall=1`, `s=1001`, `imm=2`: `pc` holds 8'h20. Drop `stall`: `pc=8'h24`.
- `pc=8'h18`, `trap_req=1` with `stall=1`: next `pc=8'h40`, `epc=8'h18`, `in_trap=1`, `trap_cause=0`.
  - Second `trap_req` in TRAP: `epc` stays 8'h18.
  - `mret`: `pc=8'h18`, `in_trap=0`.
- With `PC_MISALIGN_TRAP_EN`: `pc=8'h08`, `s=1001`, `imm=1` → `pc=8'h40`, `trap_cause=1`, `epc=8'h08`. Without the macro: `pc=8'h0A`.
- `halt=1` at `pc=8'h30`: `halted=1`, `pc` holds 8'h30 despite `trap_req`. Assert `rst_n` low mid-halt: `pc=0` and `halted=0` immediately, without waiting for a clock edge.
